// File: rtl/direct_mapped_read_cache.sv
// Direct-mapped read-allocate cache, write-around with line invalidate.
// One-cycle fill from a combinational 128-bit block memory port.
module direct_mapped_read_cache #(
  parameter int ADDR_W = 15,
  parameter int LINES  = 1024,
  parameter int WORDS  = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 memWrite,
  input  logic [ADDR_W-1:0]    cacheReadAddress,
  input  logic [ADDR_W-1:0]    memWriteAddress,
  input  logic [32*WORDS-1:0]  dataIn,
  output logic [31:0]          out,
  output logic                 Hit,
  output logic                 Miss,
  output logic [ADDR_W-1:0]    memAddress,
  output logic                 memWriteCacheOutput
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 32 * WORDS;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [BLK_W-1:0] data_q [LINES];

  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] rd_idx;
  logic [OFF_W-1:0] rd_off;
  logic [TAG_W-1:0] wr_tag;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_hit;
  logic             fill;
  logic [BLK_W-1:0] line;

  assign rd_tag = cacheReadAddress[ADDR_W-1 -: TAG_W];
  assign rd_idx = cacheReadAddress[OFF_W +: IDX_W];
  assign rd_off = cacheReadAddress[OFF_W-1:0];
  assign wr_tag = memWriteAddress[ADDR_W-1 -: TAG_W];
  assign wr_idx = memWriteAddress[OFF_W +: IDX_W];

  // Lookup, read mux and memory-side address selection.
  always_comb begin
    line   = data_q[rd_idx];
    Hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    Miss   = ~Hit;
    out    = 32'd0;
    if (Hit) begin
      out = line[32*rd_off +: 32];
    end
    wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    fill   = Miss && !memWrite;
    memWriteCacheOutput = memWrite;
    if (memWrite) begin
      memAddress = memWriteAddress;
    end else begin
      memAddress = {rd_tag, rd_idx, {OFF_W{1'b0}}};
    end
  end

  // Next valid vector: a write invalidates a matching line, else a miss allocates.
  always_comb begin
    valid_d = valid_q;
    if (memWrite) begin
      if (wr_hit) begin
        valid_d[wr_idx] = 1'b0;
      end
    end else if (fill) begin
      valid_d[rd_idx] = 1'b1;
    end
  end

  // Valid bits are the only state that reset clears.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays; a fill during reset is harmless since valid stays low.
  always_ff @(posedge clock) begin
    if (fill) begin
      tag_q[rd_idx]  <= rd_tag;
      data_q[rd_idx] <= dataIn;
    end
  end

endmodule

// File: tb/tb_direct_mapped_read_cache.sv
// Bench for direct_mapped_read_cache with a word memory model
// and a scoreboard of expected lookup results.
module tb_direct_mapped_read_cache;

  logic         clock = 1'b0;
  logic         rst;
  logic         memWrite;
  logic [14:0]  cacheReadAddress;
  logic [14:0]  memWriteAddress;
  logic [127:0] dataIn;
  logic [31:0]  out;
  logic         Hit;
  logic         Miss;
  logic [14:0]  memAddress;
  logic         memWriteCacheOutput;

  logic [31:0]  mem [32768];
  logic [31:0]  wdata;
  int           nerr = 0;
  int           nchk = 0;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    logic [14:0] maddr;
    logic        we;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  direct_mapped_read_cache dut (
    .clock               (clock),
    .rst                 (rst),
    .memWrite            (memWrite),
    .cacheReadAddress    (cacheReadAddress),
    .memWriteAddress     (memWriteAddress),
    .dataIn              (dataIn),
    .out                 (out),
    .Hit                 (Hit),
    .Miss                (Miss),
    .memAddress          (memAddress),
    .memWriteCacheOutput (memWriteCacheOutput)
  );

  // Memory model: init word k = k, word write on rising edge.
  always begin
    for (int k = 0; k < 32768; k++) mem[k] = k;
    forever begin
      @(posedge clock);
      if (memWriteCacheOutput) mem[memAddress] = wdata;
    end
  end

  assign dataIn = {mem[{memAddress[14:2], 2'd3}],
                   mem[{memAddress[14:2], 2'd2}],
                   mem[{memAddress[14:2], 2'd1}],
                   mem[{memAddress[14:2], 2'd0}]};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("hit", {31'd0, Hit}, {31'd0, e.hit});
    chk("miss", {31'd0, Miss}, {31'd0, ~e.hit});
    chk("out", out, e.data);
    chk("maddr", {17'd0, memAddress}, {17'd0, e.maddr});
    chk("we", {31'd0, memWriteCacheOutput}, {31'd0, e.we});
  endtask

  // Called at a falling edge; leaves at the next falling edge.
  task automatic rd(input logic [14:0] a, input logic eh);
    exp_t e;
    memWrite = 1'b0;
    cacheReadAddress = a;
    e.hit   = eh;
    e.data  = eh ? mem[a] : 32'd0;
    e.maddr = {a[14:2], 2'b00};
    e.we    = 1'b0;
    sb.push_back(e);
    #1;
    compare_front();
    @(negedge clock);
  endtask

  task automatic wr(input logic [14:0] a, input logic [31:0] d,
                    input logic eh);
    exp_t e;
    memWrite = 1'b1;
    memWriteAddress = a;
    wdata = d;
    e.hit   = eh;
    e.data  = eh ? mem[cacheReadAddress] : 32'd0;
    e.maddr = a;
    e.we    = 1'b1;
    sb.push_back(e);
    #1;
    compare_front();
    @(negedge clock);
    memWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    memWrite = 1'b0;
    cacheReadAddress = '0;
    memWriteAddress = '0;
    wdata = '0;
    @(negedge clock);
    #1;
    chk("rst_hit", {31'd0, Hit}, 32'd0);
    chk("rst_miss", {31'd0, Miss}, 32'd1);
    chk("rst_out", out, 32'd0);
    @(negedge clock);
    rst = 1'b1;
    rd(15'd1024, 1'b0);
    rd(15'd1024, 1'b1);
    rd(15'd1025, 1'b1);
    rd(15'd1026, 1'b1);
    rd(15'd1027, 1'b1);
    rd(15'd1028, 1'b0);
    rd(15'd1028, 1'b1);
    rd(15'd5120, 1'b0);
    rd(15'd5120, 1'b1);
    rd(15'd1024, 1'b0);
    rd(15'd1024, 1'b1);
    wr(15'd1025, 32'h0000ABCD, 1'b1);
    rd(15'd1025, 1'b0);
    rd(15'd1025, 1'b1);
    chk("wr_data", out, 32'h0000ABCD);
    rd(15'd1028, 1'b1);
    rd(15'd1024, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_hit", {31'd0, Hit}, 32'd0);
    chk("mid_rst_out", out, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("post_rst_miss", {31'd0, Miss}, 32'd1);
    @(negedge clock);
    rst = 1'b0;
    #1 rst = 1'b1;
    for (int a = 1024; a <= 9215; a++) begin
      logic [14:0] aa;
      aa = a[14:0];
      rd(aa, aa[1:0] != 2'd0);
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
